instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage of the multi-cycle processor. Holds the program counter, drives the byte address into the instruction ROM, and captures the returned 32-bit word into an instruction register. It then presents the captured instruction to the decode/control stage through a valid/ready handshake. Supports PC redirection for branches and jumps, and a configurable memory wait count so the same block serves both the combinational ROM and a future registered block-RAM ROM.

## Interface
- RESET_PC, 17'h00000: byte address loaded into PC on reset.
- WAIT_CYCLES, 0: extra cycles between driving `addr` and sampling `Inst`. Range 0–7.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- addr  out  17  byte address to the instruction ROM. Always equals the PC register.
- Inst  in  32  instruction word from the ROM for the current `addr`.
- ir  out  32  captured instruction register.
- ir_pc  out  17  byte address the word in `ir` was fetched from.
- ir_valid  out  1  `ir`/`ir_pc` hold an unconsumed instruction.
- ir_ready  in  1  downstream accepts `ir` this cycle.
- redirect  in  1  load a new PC; takes priority over sequential fetch.
- redirect_pc  in  17  branch/jump target, byte address.
- misaligned  out  1  sticky flag: a redirect arrived with `redirect_pc[1:0] != 0`.

## Operation
- States: FETCH, WAIT, HOLD. Reset state is FETCH.
- Reset values:
  - pc = RESET_PC with bits [1:0] forced to 00.
  - ir = 0, ir_pc = 0, ir_valid = 0, misaligned = 0.
  - wait counter = 0.
- FETCH:
  - If WAIT_CYCLES == 0: at the clock edge, ir ← Inst, ir_pc ← pc, pc ← pc + 4, ir_valid ← 1, go to HOLD.
  - Otherwise: counter ← WAIT_CYCLES, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter is 1: capture as in FETCH, go to HOLD.
  - `addr` is held stable throughout WAIT.
- HOLD:
  - ir_valid = 1; `ir` and `ir_pc` are held stable.
  - If ir_ready = 1: ir_valid ← 0, go to FETCH.
  - If ir_ready = 0: remain in HOLD.
- Handshake: a transfer occurs on any edge where ir_valid & ir_ready are both 1. ir_ready is ignored while ir_valid = 0.
- PC arithmetic: modulo 2^17. pc = 17'h1FFFC followed by +4 gives 17'h00000, with no flag raised. pc[1:0] is always 00.
- Redirect (any state, highest priority below reset):
  - pc ← {redirect_pc[16:2], 2'b00}, ir_valid ← 0, counter ← 0, state ← FETCH.
  - Any in-flight fetch (FETCH/WAIT) is discarded; `ir` is not updated.
  - Redirect in HOLD with ir_ready = 1: the handshake completes (instruction consumed), then the redirect applies.
  - Redirect in HOLD with ir_ready = 0: the held instruction is dropped.
  - If redirect_pc[1:0] != 0: misaligned ← 1. The flag stays set until reset.
- Reset asserted mid-operation (any state, any counter value): all registers return to reset values on that edge; redirect is ignored in that cycle.

## Timing
- Latency, with reset deasserted before edge 0 and the block in FETCH during cycle 0: ir_valid rises in cycle 1 + WAIT_CYCLES.
- Throughput with ir_ready held at 1: one instruction per 2 + WAIT_CYCLES cycles. The single FETCH bubble is intentional for the multi-cycle controller.
- Redirect asserted in cycle n: addr = target in cycle n+1; ir_valid rises in cycle n+2+WAIT_CYCLES.
- All outputs are registered except `addr`, which is a direct wire from the pc register. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/sequential fetch (WAIT_CYCLES=0):
  - Stimulus: ROM[0..3] = 0x00200093, 0x00300113, 0x002081B3, 0x40110233; ir_ready tied 1.
  - Required: ir_valid in cycles 1, 3, 5, 7; ir/ir_pc = (0x00200093, 0x00000), (0x00300113, 0x00004), (0x002081B3, 0x00008), (0x40110233, 0x0000C).
- Backpressure:
  - Stimulus: ir_ready = 0 for 5 cycles after the first ir_valid.
  - Required: ir = 0x00200093 and addr = 0x00004 held stable across those cycles; the next fetch starts only after ready.
- Wait states (WAIT_CYCLES=3):
  - Required: first ir_valid in cycle 4; addr = 0x00000 stable in cycles 0–3.
- Redirect:
  - Stimulus: redirect to 0x00010 asserted during WAIT; then redirect to 0x00021.
  - Required (first redirect): the pending fetch is dropped and the next ir_pc = 0x00010.
  - Required (second redirect): misaligned = 1, addr = 0x00020; misaligned stays 1 until reset.
- Redirect with handshake: redirect to 0x00100 in HOLD with ir_ready = 1 -> one transfer counted, next ir_pc = 0x00100.
- Wrap and mid-run reset:
  - Stimulus: redirect to 0x1FFFC, consume one instruction; later assert reset in WAIT.
  - Required: the consumed instruction has ir_pc = 0x1FFFC and the following addr = 0x00000. After the reset edge, ir_valid = 0, ir = 0, addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage of the multi-cycle processor. Holds the program counter, drives
// the byte address into the instruction ROM, captures the returned word into
// the instruction register and offers it downstream over valid/ready.
//
// Parameters
//   RESET_PC     byte address loaded into the PC on reset (bits [1:0] dropped)
//   WAIT_CYCLES  extra cycles between driving addr and sampling Inst (0..7)
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   addr         byte address to the ROM, a direct wire from the PC register
//   Inst         ROM word for the current addr
//   ir           captured instruction register
//   ir_pc        byte address the word in ir was fetched from
//   ir_valid     ir/ir_pc hold an unconsumed instruction
//   ir_ready     downstream accepts ir this cycle
//   redirect     load a new PC (branch/jump), overrides sequential fetch
//   redirect_pc  branch/jump target byte address
//   misaligned   sticky: some redirect target had non-zero bits [1:0]
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [16:0] RESET_PC    = 17'h00000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [16:0] addr,
    input  logic [31:0] Inst,
    output logic [31:0] ir,
    output logic [16:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [16:0] redirect_pc,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Word-aligned reset address; the PC never holds a non-zero byte offset.
    localparam logic [16:0] RESET_PC_ALIGNED = {RESET_PC[16:2], 2'b00};
    localparam logic [2:0]  WAIT_INIT        = 3'(WAIT_CYCLES);
    localparam bit          NO_WAIT          = (WAIT_CYCLES == 32'd0);

    state_t      state_r;
    logic [16:0] pc_r;
    logic [2:0]  cnt_r;

    logic [16:0] pc_inc_s;
    logic [2:0]  cnt_dec_s;
    logic [16:0] redirect_aligned_s;
    logic        redirect_misaligned_s;

    // The ROM address comes straight from the PC register, no input feeds it.
    assign addr = pc_r;

    // Next-address arithmetic and redirect target decoding.
    always_comb begin
        pc_inc_s              = pc_r + 17'd4;     // wraps modulo 2^17 silently
        cnt_dec_s             = cnt_r - 3'd1;
        redirect_aligned_s    = {redirect_pc[16:2], 2'b00};
        redirect_misaligned_s = (redirect_pc[1:0] != 2'b00);
    end

    // Fetch controller: PC, wait counter, instruction register and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC_ALIGNED;
            cnt_r      <= 3'd0;
            ir         <= 32'd0;
            ir_pc      <= 17'd0;
            ir_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (redirect) begin
            // Any in-flight fetch is discarded. In HOLD with ir_ready high the
            // downstream still sees this edge as a transfer, so the held word
            // counts as consumed before the redirect takes effect.
            state_r  <= ST_FETCH;
            pc_r     <= redirect_aligned_s;
            cnt_r    <= 3'd0;
            ir_valid <= 1'b0;
            if (redirect_misaligned_s) begin
                misaligned <= 1'b1;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (NO_WAIT) begin
                        ir       <= Inst;
                        ir_pc    <= pc_r;
                        pc_r     <= pc_inc_s;
                        ir_valid <= 1'b1;
                        state_r  <= ST_HOLD;
                    end else begin
                        cnt_r   <= WAIT_INIT;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // addr is held; sample Inst on the edge where count is 1.
                    if (cnt_r == 3'd1) begin
                        ir       <= Inst;
                        ir_pc    <= pc_r;
                        pc_r     <= pc_inc_s;
                        ir_valid <= 1'b1;
                        cnt_r    <= 3'd0;
                        state_r  <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_dec_s;
                    end
                end
                ST_HOLD: begin
                    // One bubble through FETCH after every transfer.
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state_r  <= ST_FETCH;
                    end
                end
                default: begin
                    state_r  <= ST_FETCH;
                    cnt_r    <= 3'd0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Two fetch stages share one ROM model: dut0 with WAIT_CYCLES=0 and dut3 with
// WAIT_CYCLES=3. Directed sequences drive each one cycle by cycle; expected
// transfers (ir, ir_pc) go into per-DUT queues which monitor processes pop on
// every valid&ready handshake.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    typedef struct {
        logic [31:0] ir;
        logic [16:0] pc;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3;
    logic [16:0] addr0, addr3;
    logic [31:0] inst0, inst3;
    logic [31:0] ir0, ir3;
    logic [16:0] irpc0, irpc3;
    logic        v0, v3;
    logic        rdy0, rdy3;
    logic        redir0, redir3;
    logic [16:0] rpc0, rpc3;
    logic        mis0, mis3;

    int n_checks = 0;
    int n_err    = 0;
    int xfer0    = 0;
    int xb;

    xfer_t q0[$];
    xfer_t q3[$];

    // Instruction ROM model: four hand-written words, a tagged pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [16:0] a);
        case (a[16:2])
            15'd0:   rom_word = 32'h00200093;
            15'd1:   rom_word = 32'h00300113;
            15'd2:   rom_word = 32'h002081B3;
            15'd3:   rom_word = 32'h40110233;
            default: rom_word = {8'hC3, 7'd0, a};
        endcase
    endfunction

    assign inst0 = rom_word(addr0);
    assign inst3 = rom_word(addr3);

    instr_fetch #(.RESET_PC(17'h00000), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst0), .addr(addr0), .Inst(inst0),
        .ir(ir0), .ir_pc(irpc0), .ir_valid(v0), .ir_ready(rdy0),
        .redirect(redir0), .redirect_pc(rpc0), .misaligned(mis0)
    );

    instr_fetch #(.RESET_PC(17'h00000), .WAIT_CYCLES(3)) dut3 (
        .clock(clk), .reset(rst3), .addr(addr3), .Inst(inst3),
        .ir(ir3), .ir_pc(irpc3), .ir_valid(v3), .ir_ready(rdy3),
        .redirect(redir3), .redirect_pc(rpc3), .misaligned(mis3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [16:0] a);
        xfer_t e;
        e.ir = rom_word(a);
        e.pc = a;
        q0.push_back(e);
    endtask

    task automatic push3(input logic [16:0] a);
        xfer_t e;
        e.ir = rom_word(a);
        e.pc = a;
        q3.push_back(e);
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut0: every handshake must match the head of its queue.
    always @(negedge clk) begin
        if (v0 === 1'b1 && rdy0 === 1'b1) begin
            xfer0++;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_xfer_pc", {15'd0, irpc0}, 32'hFFFFFFFF);
            end else begin
                xfer_t e;
                e = q0.pop_front();
                chk("dut0_xfer_ir", ir0, e.ir);
                chk("dut0_xfer_pc", {15'd0, irpc0}, {15'd0, e.pc});
            end
        end
    end

    // Monitor for dut3.
    always @(negedge clk) begin
        if (v3 === 1'b1 && rdy3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("dut3_unexpected_xfer_pc", {15'd0, irpc3}, 32'hFFFFFFFF);
            end else begin
                xfer_t e;
                e = q3.pop_front();
                chk("dut3_xfer_ir", ir3, e.ir);
                chk("dut3_xfer_pc", {15'd0, irpc3}, {15'd0, e.pc});
            end
        end
    end

    // Watchdog: the directed sequence is fixed-length, this only guards hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        rdy0 = 1'b0; rdy3 = 1'b0;
        redir0 = 1'b0; redir3 = 1'b0;
        rpc0 = 17'd0; rpc3 = 17'd0;
        next_cycle();
        next_cycle();

        // Reset state of both instances.
        @(negedge clk);
        chk("rst_valid0", {31'd0, v0}, 32'd0);
        chk("rst_ir0", ir0, 32'd0);
        chk("rst_irpc0", {15'd0, irpc0}, 32'd0);
        chk("rst_addr0", {15'd0, addr0}, 32'd0);
        chk("rst_mis0", {31'd0, mis0}, 32'd0);
        chk("rst_valid3", {31'd0, v3}, 32'd0);
        chk("rst_addr3", {15'd0, addr3}, 32'd0);

        // Sequential fetch, WAIT_CYCLES=0, ready tied high.
        push0(17'h00000); push0(17'h00004); push0(17'h00008); push0(17'h0000C);
        rdy0 = 1'b1;
        next_cycle();
        rst0 = 1'b0;                       // cycle 0
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("seq_valid", {31'd0, v0}, (c % 2 == 1) ? 32'd1 : 32'd0);
            next_cycle();
        end
        rdy0 = 1'b0;                       // cycle 8

        // Backpressure: ready low for five cycles after the first valid.
        rst0 = 1'b1;
        next_cycle();
        rst0 = 1'b0;                       // cycle 0
        @(negedge clk);
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, v0}, 32'd1);
            chk("bp_ir", ir0, 32'h00200093);
            chk("bp_irpc", {15'd0, irpc0}, 32'd0);
            chk("bp_addr", {15'd0, addr0}, 32'h00004);
            next_cycle();
        end
        push0(17'h00000);                  // cycle 6
        rdy0 = 1'b1;
        @(negedge clk);
        chk("bp_valid_at_ready", {31'd0, v0}, 32'd1);
        next_cycle();                      // cycle 7: bubble
        @(negedge clk);
        chk("bp_bubble_valid", {31'd0, v0}, 32'd0);
        chk("bp_bubble_addr", {15'd0, addr0}, 32'h00004);
        push0(17'h00004);
        next_cycle();                      // cycle 8
        @(negedge clk);
        chk("bp_next_valid", {31'd0, v0}, 32'd1);
        next_cycle();
        rdy0 = 1'b0;                       // cycle 9

        // Redirect in HOLD with ready high, then a wrapping redirect.
        rst0 = 1'b1;
        next_cycle();
        rst0 = 1'b0;                       // cycle 0
        @(negedge clk);
        next_cycle();                      // cycle 1: HOLD
        push0(17'h00000);
        rdy0 = 1'b1;
        redir0 = 1'b1;
        rpc0 = 17'h00100;
        xb = xfer0;
        @(negedge clk);
        chk("rh_valid", {31'd0, v0}, 32'd1);
        next_cycle();                      // cycle 2
        redir0 = 1'b0;
        @(negedge clk);
        chk("rh_addr", {15'd0, addr0}, 32'h00100);
        chk("rh_valid_dropped", {31'd0, v0}, 32'd0);
        chk("rh_one_xfer", xfer0, xb + 1);
        push0(17'h00100);
        next_cycle();                      // cycle 3
        @(negedge clk);
        chk("rh_next_valid", {31'd0, v0}, 32'd1);
        chk("rh_next_irpc", {15'd0, irpc0}, 32'h00100);
        next_cycle();                      // cycle 4: FETCH
        rdy0 = 1'b0;
        redir0 = 1'b1;
        rpc0 = 17'h1FFFC;
        @(negedge clk);
        next_cycle();                      // cycle 5
        redir0 = 1'b0;
        @(negedge clk);
        chk("wrap_addr_target", {15'd0, addr0}, 32'h1FFFC);
        next_cycle();                      // cycle 6: HOLD
        push0(17'h1FFFC);
        rdy0 = 1'b1;
        @(negedge clk);
        chk("wrap_valid", {31'd0, v0}, 32'd1);
        chk("wrap_addr_after", {15'd0, addr0}, 32'h00000);
        next_cycle();                      // cycle 7
        rdy0 = 1'b0;
        @(negedge clk);
        chk("wrap_bubble_addr", {15'd0, addr0}, 32'h00000);
        chk("wrap_bubble_valid", {31'd0, v0}, 32'd0);
        chk("wrap_no_mis", {31'd0, mis0}, 32'd0);

        // Wait states, WAIT_CYCLES=3.
        rst3 = 1'b1;
        next_cycle();
        rst3 = 1'b0;                       // cycle 0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ws_addr", {15'd0, addr3}, 32'd0);
            chk("ws_valid_low", {31'd0, v3}, 32'd0);
            next_cycle();
        end
        push3(17'h00000);                  // cycle 4
        rdy3 = 1'b1;
        @(negedge clk);
        chk("ws_first_valid", {31'd0, v3}, 32'd1);
        chk("ws_first_ir", ir3, 32'h00200093);
        next_cycle();                      // cycle 5: FETCH
        @(negedge clk);
        chk("ws_bubble_valid", {31'd0, v3}, 32'd0);
        chk("ws_bubble_addr", {15'd0, addr3}, 32'h00004);
        next_cycle();                      // cycle 6: WAIT, redirect
        redir3 = 1'b1;
        rpc3 = 17'h00010;
        push3(17'h00010);
        @(negedge clk);
        next_cycle();                      // cycle 7
        redir3 = 1'b0;
        @(negedge clk);
        chk("rd_addr", {15'd0, addr3}, 32'h00010);
        chk("rd_valid_low", {31'd0, v3}, 32'd0);
        chk("rd_mis_clear", {31'd0, mis3}, 32'd0);
        next_cycle();
        for (int c = 8; c <= 10; c++) begin
            @(negedge clk);
            chk("rd_wait_valid", {31'd0, v3}, 32'd0);
            next_cycle();
        end
        @(negedge clk);                    // cycle 11
        chk("rd_valid", {31'd0, v3}, 32'd1);
        chk("rd_irpc", {15'd0, irpc3}, 32'h00010);
        next_cycle();                      // cycle 12: misaligned redirect
        redir3 = 1'b1;
        rpc3 = 17'h00021;
        @(negedge clk);
        next_cycle();                      // cycle 13
        redir3 = 1'b0;
        @(negedge clk);
        chk("mis_set", {31'd0, mis3}, 32'd1);
        chk("mis_addr", {15'd0, addr3}, 32'h00020);
        push3(17'h00020);
        next_cycle();
        for (int c = 14; c <= 16; c++) begin
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);                    // cycle 17
        chk("mis_next_valid", {31'd0, v3}, 32'd1);
        chk("mis_next_irpc", {15'd0, irpc3}, 32'h00020);
        next_cycle();                      // cycle 18: FETCH
        rdy3 = 1'b0;
        @(negedge clk);
        chk("mis_sticky", {31'd0, mis3}, 32'd1);
        next_cycle();                      // cycle 19: WAIT, reset with redirect
        rst3 = 1'b1;
        redir3 = 1'b1;
        rpc3 = 17'h00041;
        @(negedge clk);
        next_cycle();                      // cycle 20
        rst3 = 1'b0;
        redir3 = 1'b0;
        @(negedge clk);
        chk("mrst_valid", {31'd0, v3}, 32'd0);
        chk("mrst_ir", ir3, 32'd0);
        chk("mrst_irpc", {15'd0, irpc3}, 32'd0);
        chk("mrst_addr", {15'd0, addr3}, 32'd0);
        chk("mrst_mis", {31'd0, mis3}, 32'd0);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
